// File: rtl/compact_inv_bf.sv
// Streaming inverse-NTT butterfly: two Gentleman-Sande stages (A/B, then C/D)
// giving either two radix-2 results or one radix-4 result, fixed 6-cycle latency.
module compact_inv_bf #(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int LAT        = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  sel,
  input  logic                  halve,
  input  logic [DATA_WIDTH-1:0] u0,
  input  logic [DATA_WIDTH-1:0] v0,
  input  logic [DATA_WIDTH-1:0] u1,
  input  logic [DATA_WIDTH-1:0] v1,
  input  logic [DATA_WIDTH-1:0] wa1,
  input  logic [DATA_WIDTH-1:0] wa2,
  input  logic [DATA_WIDTH-1:0] wa3,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] bf_0_upper,
  output logic [DATA_WIDTH-1:0] bf_0_lower,
  output logic [DATA_WIDTH-1:0] bf_1_upper,
  output logic [DATA_WIDTH-1:0] bf_1_lower
);

  localparam int DW = DATA_WIDTH;
  localparam logic [DW:0]     Q1 = (DW+1)'(Q);
  localparam logic [2*DW-1:0] Q2 = (2*DW)'(Q);
  // Barrett constant floor(2^(2*DW)/Q); quotient estimate is low by at most one
  localparam logic [4*DW:0]   BM = (4*DW+1)'((64'd1 << (2*DW)) / 64'(Q));

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= Q1) t = t - Q1;
    return DW'(t);
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + Q1 - {1'b0, b};
    return DW'(t);
  endfunction

  function automatic logic [2*DW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (2*DW)'(a) * (2*DW)'(b);
  endfunction

  function automatic logic [DW-1:0] mod_red(input logic [2*DW-1:0] p);
    logic [4*DW:0]   qm;
    logic [2*DW-1:0] qe;
    logic [2*DW-1:0] r;
    qm = (4*DW+1)'(p) * BM;
    qe = (2*DW)'(qm >> (2*DW));
    r  = p - qe * Q2;
    if (r >= Q2) r = r - Q2;
    return DW'(r);
  endfunction

  // Multiply by 2^-1 mod Q: odd values are made even by adding the odd modulus
  function automatic logic [DW-1:0] hv(input logic [DW-1:0] x, input logic en);
    logic [DW:0] t;
    if (en && x[0]) t = {1'b0, x} + Q1;
    else            t = {1'b0, x};
    return en ? DW'(t >> 1) : x;
  endfunction

  logic [LAT-1:0] vld;
  logic [DW-1:0]  sa1, da1, sb1, db1, w1_1, w2_1, w3_1;
  logic           sel1, h1;
  logic [DW-1:0]  sa2, sb2, w3_2;
  logic [2*DW-1:0] pa2, pb2;
  logic           sel2, h2;
  logic [DW-1:0]  au3, al3, bu3, bl3, w3_3;
  logic           sel3, h3;
  logic [DW-1:0]  sc4, dc4, sd4, dd4, w3_4;
  logic [4*DW-1:0] byp4;
  logic           sel4, h4;
  logic [DW-1:0]  sc5, sd5;
  logic [2*DW-1:0] pc5, pd5;
  logic [4*DW-1:0] byp5;
  logic           sel5, h5;

  // Valid shift register; out_valid is its last tap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld <= '0;
    else     vld <= {vld[LAT-2:0], in_valid};
  end
  assign out_valid = vld[LAT-1];

  // Stage 1: modular sum/difference of the A and B butterflies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {sa1, da1, sb1, db1, w1_1, w2_1, w3_1, sel1, h1} <= '0;
    end else if (in_valid) begin
      sa1 <= mod_add(u0, v0);  da1 <= mod_sub(u0, v0);
      sb1 <= mod_add(u1, v1);  db1 <= mod_sub(u1, v1);
      w1_1 <= wa1;  w2_1 <= wa2;  w3_1 <= wa3;
      sel1 <= sel;  h1 <= halve;
    end
  end

  // Stage 2: twiddle products for A and B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {sa2, sb2, pa2, pb2, w3_2, sel2, h2} <= '0;
    end else if (vld[0]) begin
      sa2 <= sa1;  sb2 <= sb1;
      pa2 <= mul(da1, w1_1);  pb2 <= mul(db1, w2_1);
      w3_2 <= w3_1;  sel2 <= sel1;  h2 <= h1;
    end
  end

  // Stage 3: reduction and optional halving complete A and B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {au3, al3, bu3, bl3, w3_3, sel3, h3} <= '0;
    end else if (vld[1]) begin
      au3 <= hv(sa2, h2);  al3 <= hv(mod_red(pa2), h2);
      bu3 <= hv(sb2, h2);  bl3 <= hv(mod_red(pb2), h2);
      w3_3 <= w3_2;  sel3 <= sel2;  h3 <= h2;
    end
  end

  // Stage 4: C pairs the uppers, D pairs the lowers; A/B also enter the bypass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {sc4, dc4, sd4, dd4, byp4, w3_4, sel4, h4} <= '0;
    end else if (vld[2]) begin
      sc4 <= mod_add(au3, bu3);  dc4 <= mod_sub(au3, bu3);
      sd4 <= mod_add(al3, bl3);  dd4 <= mod_sub(al3, bl3);
      byp4 <= {au3, al3, bu3, bl3};
      w3_4 <= w3_3;  sel4 <= sel3;  h4 <= h3;
    end
  end

  // Stage 5: twiddle products for C and D
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {sc5, sd5, pc5, pd5, byp5, sel5, h5} <= '0;
    end else if (vld[3]) begin
      sc5 <= sc4;  sd5 <= sd4;
      pc5 <= mul(dc4, w3_4);  pd5 <= mul(dd4, w3_4);
      byp5 <= byp4;  sel5 <= sel4;  h5 <= h4;
    end
  end

  // Stage 6: output registers hold the last valid result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower} <= '0;
    end else if (vld[4]) begin
      if (sel5) begin
        bf_0_upper <= hv(sc5, h5);
        bf_1_upper <= hv(mod_red(pc5), h5);
        bf_0_lower <= hv(sd5, h5);
        bf_1_lower <= hv(mod_red(pd5), h5);
      end else begin
        {bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower} <= byp5;
      end
    end
  end

endmodule

// File: tb/tb_compact_inv_bf.sv
// Directed-vector bench for compact_inv_bf with a plain-arithmetic reference for
// the streaming and reset scenarios.
module tb_compact_inv_bf;
  localparam int DW = 12;
  localparam int QM = 3329;
  localparam int INV2 = 1665;

  logic clk, rst, in_valid, sel, halve;
  logic [DW-1:0] u0, v0, u1, v1, wa1, wa2, wa3;
  logic out_valid;
  logic [DW-1:0] bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower;

  int vec_cnt = 0;
  int miss_cnt = 0;

  compact_inv_bf #(.DATA_WIDTH(DW), .Q(QM), .LAT(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel), .halve(halve),
    .u0(u0), .v0(v0), .u1(u1), .v1(v1), .wa1(wa1), .wa2(wa2), .wa3(wa3),
    .out_valid(out_valid), .bf_0_upper(bf_0_upper), .bf_0_lower(bf_0_lower),
    .bf_1_upper(bf_1_upper), .bf_1_lower(bf_1_lower)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e0u, input int e0l, input int e1u, input int e1l);
    check({tag, ".b0u"}, int'(bf_0_upper), e0u);
    check({tag, ".b0l"}, int'(bf_0_lower), e0l);
    check({tag, ".b1u"}, int'(bf_1_upper), e1u);
    check({tag, ".b1l"}, int'(bf_1_lower), e1l);
  endtask

  function automatic void gs(input int u, input int v, input int w, input bit h,
                             output int up, output int lo);
    up = (u + v) % QM;
    lo = (((u - v + QM) % QM) * w) % QM;
    if (h) begin
      up = (up * INV2) % QM;
      lo = (lo * INV2) % QM;
    end
  endfunction

  function automatic void model(input bit s, input bit h, input int a0, input int b0,
                                input int a1, input int b1, input int w1, input int w2,
                                input int w3, output int o0u, output int o0l,
                                output int o1u, output int o1l);
    int au, al, bu, bl, cu, cl, du, dl;
    gs(a0, b0, w1, h, au, al);
    gs(a1, b1, w2, h, bu, bl);
    gs(au, bu, w3, h, cu, cl);
    gs(al, bl, w3, h, du, dl);
    if (s) begin o0u = cu; o1u = cl; o0l = du; o1l = dl; end
    else   begin o0u = au; o0l = al; o1u = bu; o1l = bl; end
  endfunction

  task automatic drive(input bit s, input bit h, input int a0, input int b0, input int a1,
                       input int b1, input int w1, input int w2, input int w3);
    in_valid = 1'b1; sel = s; halve = h;
    u0 = DW'(a0); v0 = DW'(b0); u1 = DW'(a1); v1 = DW'(b1);
    wa1 = DW'(w1); wa2 = DW'(w2); wa3 = DW'(w3);
  endtask

  // One isolated set, latency checked on both sides of the 6th cycle
  task automatic run_dir(input string tag, input bit s, input bit h, input int a0, input int b0,
                         input int a1, input int b1, input int w1, input int w2, input int w3,
                         input int e0u, input int e0l, input int e1u, input int e1l);
    drive(s, h, a0, b0, a1, b1, w1, w2, w3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, ".early"}, int'(out_valid), 0);
    @(negedge clk);
    check({tag, ".valid"}, int'(out_valid), 1);
    check_outs(tag, e0u, e0l, e1u, e1l);
    @(negedge clk);
    check({tag, ".drop"}, int'(out_valid), 0);
    check_outs({tag, ".hold"}, e0u, e0l, e1u, e1l);
  endtask

  int e0u[16], e0l[16], e1u[16], e1l[16];

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 1'b0; halve = 1'b0;
    u0 = '0; v0 = '0; u1 = '0; v1 = '0; wa1 = '0; wa2 = '0; wa3 = '0;
    repeat (2) @(negedge clk);
    check("reset.valid", int'(out_valid), 0);
    check_outs("reset", 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    run_dir("t1", 1'b0, 1'b0, 5, 3, 3, 5, 17, 1, 0, 8, 34, 8, 3327);
    run_dir("t2", 1'b0, 1'b1, 1, 0, 2, 0, 1, 1, 0, 1665, 1665, 1, 1);
    run_dir("t3", 1'b1, 1'b0, 1, 2, 3, 4, 1, 1, 1, 10, 3327, 3325, 0);
    run_dir("t4", 1'b0, 1'b0, 3328, 0, 3328, 3328, 3328, 5, 0, 3328, 1, 3327, 0);
    // radix-4 with halving: (1,2,3,4) w=1 scaled by 1/4
    run_dir("t4h", 1'b1, 1'b1, 1, 2, 3, 4, 1, 1, 1,
            (10 * 2497) % QM, (3327 * 2497) % QM, (3325 * 2497) % QM, 0);

    // Back-to-back stream with alternating modes
    for (int t = 0; t < 23; t++) begin
      if (t >= 6 && t < 22) begin
        check($sformatf("s%0d.valid", t - 6), int'(out_valid), 1);
        check_outs($sformatf("s%0d", t - 6), e0u[t-6], e0l[t-6], e1u[t-6], e1l[t-6]);
      end else if (t == 22) begin
        check("stream.drop", int'(out_valid), 0);
        check_outs("stream.hold", e0u[15], e0l[15], e1u[15], e1l[15]);
      end else begin
        check($sformatf("stream.pre%0d", t), int'(out_valid), 0);
      end
      if (t < 16) begin
        int a0, b0, a1, b1, w1, w2, w3;
        a0 = $urandom_range(QM - 1, 0); b0 = $urandom_range(QM - 1, 0);
        a1 = $urandom_range(QM - 1, 0); b1 = $urandom_range(QM - 1, 0);
        w1 = $urandom_range(QM - 1, 0); w2 = $urandom_range(QM - 1, 0);
        w3 = $urandom_range(QM - 1, 0);
        model(t[0], t[1], a0, b0, a1, b1, w1, w2, w3, e0u[t], e0l[t], e1u[t], e1l[t]);
        drive(t[0], t[1], a0, b0, a1, b1, w1, w2, w3);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Reset with three sets in flight
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 1'b0, 100 + t, 7, 9, 200, 3, 4, 5);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst.valid", int'(out_valid), 0);
    check_outs("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      check($sformatf("rst.quiet%0d", t), int'(out_valid), 0);
    end
    run_dir("post", 1'b0, 1'b0, 5, 3, 3, 5, 17, 1, 0, 8, 34, 8, 3327);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
